result_writeback: RTL and testbench

Downstream stage of save_send in the PairHMM diagonal datapath.
- Drains 64-bit likelihood results from save_send's result FIFO.
- Serialises each result into two 32-bit words and writes them to the PCIe-side result RAM.
- Pulses result_done to the host once the expected number of results for a batch has been written.

---
 rtl/pairhmm_wb_pkg.sv | 18 +
 rtl/result_writeback.sv | 127 ++++++++++++
 tb/tb_result_writeback.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pairhmm_wb_pkg.sv
// Shared types and default widths for the PairHMM result writeback path.
package pairhmm_wb_pkg;

    localparam int DATA_W           = 64;
    localparam int RAM_DW           = 32;
    localparam int ADDR_W           = 16;
    localparam int WORDS_PER_RESULT = DATA_W / RAM_DW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LAT   = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } wb_state_t;

endpackage

// File: rtl/result_writeback.sv
// Drains 64-bit results from save_send's FIFO, writes them as low/high 32-bit words
// into the result RAM and pulses result_done once the batch count has been written.
module result_writeback #(
    parameter int                DATA_W    = pairhmm_wb_pkg::DATA_W,
    parameter int                RAM_DW    = pairhmm_wb_pkg::RAM_DW,
    parameter int                ADDR_W    = pairhmm_wb_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              batch_start,
    input  logic [15:0]       batch_count,
    input  logic              result_fifo_empty,
    output logic              result_fifo_rden,
    input  logic [DATA_W-1:0] result_fifo_rdat,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [RAM_DW-1:0] ram_wdat,
    output logic              result_done,
    output logic              busy,
    output logic [15:0]       result_cnt,
    output logic              err_start_busy
);
    import pairhmm_wb_pkg::*;

    wb_state_t         state_q, state_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] hold_q;
    logic              wren_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [RAM_DW-1:0] wdat_q;
    logic              done_q;

    // FIFO is normal-mode: data appears the cycle after the strobe, i.e. in LAT.
    assign result_fifo_rden = (state_q == ST_WAIT) && !result_fifo_empty;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if (batch_start && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (batch_start) begin
                    err_d       = 1'b0;
                    cnt_d       = 16'd0;
                    addr_d      = BASE_ADDR;
                    remaining_d = batch_count;
                    state_d     = (batch_count == 16'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (result_fifo_rden) begin
                    state_d = ST_LAT;
                end
            end
            ST_LAT: begin
                state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                addr_d      = addr_q + ADDR_W'(1);
                cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            wren_q      <= 1'b0;
            waddr_q     <= '0;
            wdat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            done_q      <= (state_q == ST_DONE);
            wren_q      <= (state_d == ST_WR_LO) || (state_d == ST_WR_HI);
            // RAM port is registered, so each word is staged one cycle ahead of its write state.
            if (state_q == ST_LAT) begin
                hold_q  <= result_fifo_rdat;
                wdat_q  <= result_fifo_rdat[RAM_DW-1:0];
                waddr_q <= addr_q;
            end
            if (state_q == ST_WR_LO) begin
                wdat_q  <= hold_q[DATA_W-1:RAM_DW];
                waddr_q <= addr_d;
            end
        end
    end

    assign ram_wren       = wren_q;
    assign ram_waddr      = waddr_q;
    assign ram_wdat       = wdat_q;
    assign result_done    = done_q;
    assign busy           = (state_q != ST_IDLE);
    assign result_cnt     = cnt_q;
    assign err_start_busy = err_q;

endmodule

// File: tb/tb_result_writeback.sv
// Bench: two writeback instances (base 0 and base FFFE) share one FIFO model; writes are
// checked against the words the FIFO handed out, in low/high order from the base address.
`timescale 1ns/1ps
module tb_result_writeback;

    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFE;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        batch_start;
    logic [15:0] batch_count;
    logic        result_fifo_empty;
    logic [63:0] result_fifo_rdat;
    logic        rden           [2];
    logic        ram_wren       [2];
    logic [15:0] ram_waddr      [2];
    logic [31:0] ram_wdat       [2];
    logic        result_done    [2];
    logic        busy           [2];
    logic [15:0] result_cnt     [2];
    logic        err_start_busy [2];

    always #5 sys_clk = ~sys_clk;

    result_writeback #(.DATA_W(64), .RAM_DW(32), .ADDR_W(16), .BASE_ADDR(BASE0)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .batch_start(batch_start), .batch_count(batch_count),
        .result_fifo_empty(result_fifo_empty), .result_fifo_rden(rden[0]),
        .result_fifo_rdat(result_fifo_rdat),
        .ram_wren(ram_wren[0]), .ram_waddr(ram_waddr[0]), .ram_wdat(ram_wdat[0]),
        .result_done(result_done[0]), .busy(busy[0]), .result_cnt(result_cnt[0]),
        .err_start_busy(err_start_busy[0])
    );

    result_writeback #(.DATA_W(64), .RAM_DW(32), .ADDR_W(16), .BASE_ADDR(BASE1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .batch_start(batch_start), .batch_count(batch_count),
        .result_fifo_empty(result_fifo_empty), .result_fifo_rden(rden[1]),
        .result_fifo_rdat(result_fifo_rdat),
        .ram_wren(ram_wren[1]), .ram_waddr(ram_waddr[1]), .ram_wdat(ram_wdat[1]),
        .result_done(result_done[1]), .busy(busy[1]), .result_cnt(result_cnt[1]),
        .err_start_busy(err_start_busy[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] base_of(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    // FIFO environment model: normal-mode read, data valid the cycle after rden.
    logic [63:0] fifo_q [$];
    logic [63:0] popped [$];
    logic        push_vld;
    logic [63:0] push_dat;
    int          rd_cnt = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_q.delete();
            result_fifo_empty <= 1'b1;
            result_fifo_rdat  <= '0;
        end else begin
            if (rden[0] || rden[1]) begin
                check_val("rden_pair", rden[1], rden[0]);
                check_val("rden_while_empty", result_fifo_empty, 1'b0);
                if (fifo_q.size() != 0) begin
                    result_fifo_rdat <= fifo_q[0];
                    popped.push_back(fifo_q.pop_front());
                end
                rd_cnt++;
            end
            if (push_vld) fifo_q.push_back(push_dat);
            result_fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Write / done monitor, sampled mid-cycle.
    int cyc = 0;
    int wr_cnt   [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    int wr_cyc0  [$];
    int wr_base  [2] = '{0, 0};
    int done_base[2] = '{0, 0};
    int pop_base = 0;
    int rd_base  = 0;
    int start_cyc = 0;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_wren[i]) begin
                int          k;
                logic [63:0] w;
                logic [15:0] ea;
                k = wr_cnt[i] - wr_base[i];
                if (pop_base + k / 2 < popped.size()) begin
                    w  = popped[pop_base + k / 2];
                    ea = base_of(i) + 16'(k);
                    check_val($sformatf("waddr%0d_%0d", i, k), ram_waddr[i], ea);
                    check_val($sformatf("wdat%0d_%0d", i, k), ram_wdat[i],
                              (k % 2 == 1) ? w[63:32] : w[31:0]);
                end else begin
                    check_val($sformatf("spurious_wr%0d", i), ram_wren[i], 1'b0);
                end
                if (i == 0) wr_cyc0.push_back(cyc);
                wr_cnt[i]++;
            end
            if (result_done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        push_vld = 1'b1;
        push_dat = d;
        tick();
        push_vld = 1'b0;
    endtask

    task automatic start_batch(input logic [15:0] n);
        for (int i = 0; i < 2; i++) begin
            wr_base[i]   = wr_cnt[i];
            done_base[i] = done_cnt[i];
        end
        pop_base    = popped.size();
        rd_base     = rd_cnt;
        start_cyc   = cyc;
        batch_start = 1'b1;
        batch_count = n;
        tick();
        batch_start = 1'b0;
        batch_count = 16'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt[0] == done_base[0] && t < budget) begin
            tick();
            t++;
        end
        check_val("done_seen", done_cnt[0] - done_base[0], 1);
    endtask

    task automatic end_batch(input int n, input logic exp_err, input int budget);
        wait_done(budget);
        check_val("busy_after_done", busy[0], 1'b0);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("done_pulses%0d", i), done_cnt[i] - done_base[i], 1);
            check_val($sformatf("wr_count%0d", i), wr_cnt[i] - wr_base[i], 2 * n);
            check_val($sformatf("result_cnt%0d", i), result_cnt[i], n);
            check_val($sformatf("busy%0d", i), busy[i], 1'b0);
            check_val($sformatf("err%0d", i), err_start_busy[i], exp_err);
        end
        check_val("rd_count", rd_cnt - rd_base, n);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_rden%0d", tag, i), rden[i], 1'b0);
            check_val($sformatf("%s_wren%0d", tag, i), ram_wren[i], 1'b0);
            check_val($sformatf("%s_waddr%0d", tag, i), ram_waddr[i], 16'h0);
            check_val($sformatf("%s_wdat%0d", tag, i), ram_wdat[i], 32'h0);
            check_val($sformatf("%s_done%0d", tag, i), result_done[i], 1'b0);
            check_val($sformatf("%s_busy%0d", tag, i), busy[i], 1'b0);
            check_val($sformatf("%s_cnt%0d", tag, i), result_cnt[i], 16'h0);
            check_val($sformatf("%s_err%0d", tag, i), err_start_busy[i], 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n   = 1'b0;
        batch_start = 1'b0;
        batch_count = 16'h0;
        push_vld    = 1'b0;
        push_dat    = '0;
        repeat (3) tick();
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // 1: single known result
        push(64'h0123_4567_89AB_CDEF);
        tick();
        start_batch(16'd1);
        check_val("t1_busy", busy[0], 1'b1);
        end_batch(1, 1'b0, 50);
        check_val("t1_done_cyc", done_cyc[0], start_cyc + 6);
        check_val("t1_last_wdat", ram_wdat[0], 32'h0123_4567);
        check_val("t1_last_waddr", ram_waddr[0], 16'h0001);

        // 2: eight back-to-back results, FIFO never empty
        for (int j = 0; j < 8; j++) push({$urandom, $urandom});
        tick();
        start_batch(16'd8);
        end_batch(8, 1'b0, 100);
        check_val("t2_done_cyc", done_cyc[0], start_cyc + 2 + 4 * 8);
        for (int k = 0; k < 16; k++) begin
            check_val($sformatf("t2_wr_cyc%0d", k), wr_cyc0[wr_base[0] + k],
                      start_cyc + 3 + 4 * (k / 2) + (k % 2));
        end

        // 3: starved FIFO, results arrive 50 cycles apart
        start_batch(16'd3);
        for (int j = 0; j < 3; j++) begin
            repeat (50) tick();
            if (j == 2) begin
                check_val("t3_wr_before_last", wr_cnt[0] - wr_base[0], 4);
                check_val("t3_no_early_done", done_cnt[0] - done_base[0], 0);
            end
            push({$urandom, $urandom});
        end
        end_batch(3, 1'b0, 50);

        // 4: zero count, plus a start landing in the DONE cycle
        start_batch(16'd0);
        batch_start = 1'b1;
        batch_count = 16'd7;
        tick();
        batch_start = 1'b0;
        end_batch(0, 1'b1, 10);
        check_val("t4_done_cyc", done_cyc[0], start_cyc + 2);
        repeat (10) tick();
        check_val("t4_stray_ignored_rd", rd_cnt - rd_base, 0);
        check_val("t4_stray_ignored_busy", busy[0], 1'b0);

        // 5: accepted start clears error; mid-batch start ignored; dut1 wraps FFFF->0000
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        tick();
        start_batch(16'd2);
        check_val("t5_err_cleared", err_start_busy[0], 1'b0);
        tick();
        batch_start = 1'b1;
        batch_count = 16'd9;
        tick();
        batch_start = 1'b0;
        check_val("t5_err_set", err_start_busy[1], 1'b1);
        end_batch(2, 1'b1, 50);
        check_val("t5_wrap_last_addr", ram_waddr[1], 16'h0001);

        // 6: asynchronous reset during WR_HI, then a fresh batch
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        tick();
        start_batch(16'd2);
        while (cyc < start_cyc + 4) tick();
        check_val("t6_in_wr_hi", ram_wren[0], 1'b1);
        #2 sys_rst_n = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        push({$urandom, $urandom});
        tick();
        start_batch(16'd1);
        check_val("t6_cnt_restart", result_cnt[0], 16'h0);
        end_batch(1, 1'b0, 50);
        check_val("t6_last_waddr1", ram_waddr[1], 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
